inv_mix_col: RTL and testbench

INV_MIX_COL -- requirements
Module: inv_mix_col

---
 rtl/inv_mix_col.sv | 217 +++++++++++++++++++++
 tb/tb_inv_mix_col.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_col.sv
// ---------------------------------------------------------------------------
// inv_mix_col
//   Iterative AES InvMixColumns over one 128-bit state. The state is
//   captured on accept, then transformed one column per clock (columns 0..3)
//   and held in the output register until the downstream consumer takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   din carries a state to transform
//   in_ready   block can accept a state (IDLE only)
//   din[127:0] input state; column c = din[127-32c -: 32], byte r of a
//              column at [127-32c-8r -: 8]
//   out_valid  dout holds a completed result (DONE only)
//   out_ready  downstream accepts dout
//   dout[127:0] InvMixColumns result, same byte layout as din
// ---------------------------------------------------------------------------
module inv_mix_col (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [1:0]     cnt_r;
    logic [127:0]   src_r;
    logic [127:0]   dout_r;
    logic           out_valid_r;
    logic           in_ready_r;

    logic           accept_s;
    logic [31:0]    col_in_s;
    logic [31:0]    col_out_s;

    // ---------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11B. All constant multiplies
    // are composed from the x2/x4/x8 chain so results stay 8 bits wide.
    // ---------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        mul_09 = x8 ^ a;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        mul_0b = x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        mul_0d = x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        mul_0e = x8 ^ x4 ^ x2;
    endfunction

    // One column: a0 is the most significant byte of the 32-bit word.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
        b1 = mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3);
        b2 = mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3);
        b3 = mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3);
        inv_col = {b0, b1, b2, b3};
    endfunction

    // Handshake decode: a state is taken only while sitting in IDLE.
    always_comb begin
        accept_s = in_valid & (state_r == IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 2'd3) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Select the source column addressed by the column counter.
    always_comb begin
        col_in_s = 32'h0000_0000;
        case (cnt_r)
            2'd0:    col_in_s = src_r[127:96];
            2'd1:    col_in_s = src_r[95:64];
            2'd2:    col_in_s = src_r[63:32];
            2'd3:    col_in_s = src_r[31:0];
            default: col_in_s = 32'h0000_0000;
        endcase
    end

    // Column transform for the currently addressed column.
    always_comb begin
        col_out_s = inv_col(col_in_s);
    end

    // Source capture, column counter and result assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_r  <= 128'h0;
            cnt_r  <= 2'd0;
            dout_r <= 128'h0;
        end else if (accept_s) begin
            // src_r is frozen afterwards, so later din activity is harmless
            src_r <= din;
            cnt_r <= 2'd0;
        end else if (state_r == CALC) begin
            // counter wraps to 0 after column 3, but the FSM leaves CALC then
            cnt_r <= cnt_r + 2'd1;
            case (cnt_r)
                2'd0:    dout_r[127:96] <= col_out_s;
                2'd1:    dout_r[95:64]  <= col_out_s;
                2'd2:    dout_r[63:32]  <= col_out_s;
                2'd3:    dout_r[31:0]   <= col_out_s;
                default: dout_r         <= dout_r;
            endcase
        end
    end

    // Handshake flags registered from the next state so they are glitch-free
    // and mutually exclusive by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= (state_s == DONE);
            in_ready_r  <= (state_s == IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;

endmodule

// File: tb/tb_inv_mix_col.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_col
//   Directed bench for inv_mix_col: reset values, known-answer vectors,
//   back-pressure hold, din scrambling during CALC, reset abort mid-CALC and
//   a MixColumns -> InvMixColumns round trip with in_valid held high.
// ---------------------------------------------------------------------------
module tb_inv_mix_col;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;

    int n_cmp;
    int n_bad;
    int cyc;

    localparam logic [127:0] VEC_A_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] VEC_A_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] VEC_C6    = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] VEC_F_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] VEC_F_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    inv_mix_col dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle; handshake flags must never overlap.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid & in_ready) begin
            check_eq("excl", {126'h0, out_valid, in_ready}, 128'h0);
        end
    endtask

    // Forward MixColumns, used only to build round-trip stimulus.
    function automatic logic [7:0] x2(input logic [7:0] a);
        x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mixc(input logic [127:0] s);
        logic [127:0] r;
        logic [31:0]  c;
        logic [7:0]   a0, a1, a2, a3;
        r = 128'h0;
        for (int k = 0; k < 4; k++) begin
            c  = s[127-32*k -: 32];
            a0 = c[31:24];
            a1 = c[23:16];
            a2 = c[15:8];
            a3 = c[7:0];
            r[127-32*k -: 32] = {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                                 x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
        end
        mixc = r;
    endfunction

    // One complete transfer: accept, bounded wait for result, optional hold.
    task automatic do_xfer(input string tag, input logic [127:0] d, input logic [127:0] e,
                           input int hold, input bit scramble);
        int n;
        din       = d;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_rdy"}, {127'h0, in_ready}, 128'h1);
        step();
        check_eq({tag, "_busy"}, {126'h0, out_valid, in_ready}, 128'h0);
        in_valid = scramble;
        n = 0;
        while (!out_valid && n < 20) begin
            if (scramble) begin
                din = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            n++;
        end
        check_eq({tag, "_lat"}, 128'(n), 128'd4);
        check_eq({tag, "_dout"}, dout, e);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            din      = ~d;
            step();
            check_eq({tag, "_hold_ov"}, {127'h0, out_valid}, 128'h1);
            check_eq({tag, "_hold_ir"}, {127'h0, in_ready}, 128'h0);
            check_eq({tag, "_hold_dout"}, dout, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq({tag, "_end_ov"}, {127'h0, out_valid}, 128'h0);
        check_eq({tag, "_end_ir"}, {127'h0, in_ready}, 128'h1);
    endtask

    initial begin
        logic [127:0] orig;
        int           n;
        int           prev_acc;
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = 128'h0;

        // Reset values while rst is held.
        #3;
        check_eq("rst_ir", {127'h0, in_ready}, 128'h1);
        check_eq("rst_ov", {127'h0, out_valid}, 128'h0);
        check_eq("rst_dout", dout, 128'h0);
        step();
        rst = 1'b0;

        // Known-answer vectors, immediate accept on first edge after reset.
        do_xfer("vec_a", VEC_A_IN, VEC_A_OUT, 0, 1'b0);
        do_xfer("vec_c6", VEC_C6, VEC_C6, 0, 1'b0);
        // Back-pressure: result held for 10 cycles, in_valid pulses ignored.
        do_xfer("vec_fips_hold", VEC_F_IN, VEC_F_OUT, 10, 1'b0);
        // din and in_valid toggled throughout CALC.
        do_xfer("vec_a_scr", VEC_A_IN, VEC_A_OUT, 0, 1'b1);

        // Reset abort at counter == 2.
        din       = VEC_A_IN;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_ov", {127'h0, out_valid}, 128'h0);
        check_eq("abort_dout", dout, 128'h0);
        check_eq("abort_ir", {127'h0, in_ready}, 128'h1);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("abort_no_ov", {127'h0, out_valid}, 128'h0);
        end
        do_xfer("vec_a_post", VEC_A_IN, VEC_A_OUT, 0, 1'b0);

        // Round trip with in_valid held high; accepts every 6 cycles.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            din  = mixc(orig);
            n = 0;
            while (!in_ready && n < 20) begin
                step();
                n++;
            end
            step();
            if (i > 0) begin
                check_eq("rt_space", 128'(cyc - prev_acc), 128'd6);
            end
            prev_acc = cyc;
            n = 0;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
            check_eq("rt_dout", dout, orig);
            step();
        end
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
